// File: rtl/hdmi_mon_pkg.sv
// Shared constants and types for the sink-side HDMI timing monitor.
package hdmi_mon_pkg;

    localparam int unsigned H_TOTAL_1080P  = 2200;
    localparam int unsigned H_ACTIVE_1080P = 1920;
    localparam int unsigned V_TOTAL_1080P  = 1125;
    localparam int unsigned V_ACTIVE_1080P = 1080;

    localparam int unsigned      CNT_W   = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        StSearch,
        StMeasure,
        StLocked
    } mon_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, inc};
    endfunction

endpackage

// File: rtl/vid_axis_meas.sv
// Generic period/active counter: counts ticks and active ticks between leading edges.
// The tick coinciding with a leading edge closes the period that is ending.
module vid_axis_meas
    import hdmi_mon_pkg::*;
#(
    parameter bit HOLD_ACTIVE = 1'b1
) (
    input  logic             clk_148_5,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic             active_i,
    input  logic             lead_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] active_len_o
);

    logic [CNT_W-1:0] cnt_q, act_q, period_q, active_len_q;
    logic [CNT_W-1:0] cnt_d, act_d;

    assign cnt_d = sat_inc(cnt_q, tick_i);
    assign act_d = sat_inc(act_q, tick_i & active_i);

    always_ff @(posedge clk_148_5 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            act_q        <= '0;
            period_q     <= '0;
            active_len_q <= '0;
        end else if (lead_i) begin
            period_q <= cnt_d;
            cnt_q    <= '0;
            act_q    <= '0;
            // With HOLD_ACTIVE, periods without any active tick keep the previous value
            if (!HOLD_ACTIVE || act_d != '0) begin
                active_len_q <= act_d;
            end
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    assign period_o     = period_q;
    assign active_len_o = active_len_q;

endmodule

// File: rtl/hdmi_timing_monitor.sv
// Passive 1080p60 stream monitor: measures h/v timing, tracks lock and sums pixels per frame.
// Sync edges are detected one clock after the input register; results land one clock later.
module hdmi_timing_monitor
    import hdmi_mon_pkg::*;
#(
    parameter int unsigned H_TOTAL     = H_TOTAL_1080P,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_1080P,
    parameter int unsigned V_TOTAL     = V_TOTAL_1080P,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_1080P,
    parameter bit          HS_POL      = 1'b1,
    parameter bit          VS_POL      = 1'b1,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic             clk_148_5,
    input  logic             reset_n,
    input  logic             vid_hs,
    input  logic             vid_vs,
    input  logic             vid_de,
    input  logic [7:0]       vid_r,
    input  logic [7:0]       vid_g,
    input  logic [7:0]       vid_b,
    output logic [CNT_W-1:0] meas_h_total,
    output logic [CNT_W-1:0] meas_h_active,
    output logic [CNT_W-1:0] meas_v_total,
    output logic [CNT_W-1:0] meas_v_active,
    output logic             meas_valid,
    output logic             fmt_match,
    output logic             locked,
    output logic             frame_done,
    output logic [31:0]      frame_sum,
    output logic [15:0]      err_count
);

    localparam int unsigned      TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

    logic             hs_q, vs_q, de_q;
    logic [7:0]       r_q, g_q, b_q;
    logic             hs_prev_q, vs_prev_q, line_de_q, vs_edge_q;
    logic             hs_a, vs_a, hs_lead, vs_lead, line_has_de;
    logic [9:0]       pix;
    logic [31:0]      sum_q, sum_d, sum_snap_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             timeout;
    logic [CNT_W-1:0] line_len, de_len, v_total, v_active;
    logic             fmt_ok;
    mon_state_e       state_q;
    logic [3:0]       match_cnt_q;

    assign hs_a        = ~(hs_q ^ HS_POL);
    assign vs_a        = ~(vs_q ^ VS_POL);
    assign hs_lead     = hs_a & ~hs_prev_q;
    assign vs_lead     = vs_a & ~vs_prev_q;
    assign line_has_de = line_de_q | de_q;
    assign pix         = {2'b00, r_q} + {2'b00, g_q} + {2'b00, b_q};
    assign sum_d       = sum_q + (de_q ? {22'd0, pix} : 32'd0);
    assign timeout     = (to_cnt_q == TO_LAST) && !hs_lead;

    always_ff @(posedge clk_148_5 or negedge reset_n) begin
        if (!reset_n) begin
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            de_q       <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            line_de_q  <= 1'b0;
            vs_edge_q  <= 1'b0;
            sum_q      <= '0;
            sum_snap_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            hs_q      <= vid_hs;
            vs_q      <= vid_vs;
            de_q      <= vid_de;
            r_q       <= vid_r;
            g_q       <= vid_g;
            b_q       <= vid_b;
            hs_prev_q <= hs_a;
            vs_prev_q <= vs_a;
            vs_edge_q <= vs_lead;
            if (hs_lead) begin
                line_de_q <= 1'b0;
            end else if (de_q) begin
                line_de_q <= 1'b1;
            end
            if (vs_lead) begin
                sum_snap_q <= sum_d;
                sum_q      <= '0;
            end else begin
                sum_q <= sum_d;
            end
            if (hs_lead) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_LAST) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    vid_axis_meas #(
        .HOLD_ACTIVE (1'b1)
    ) u_h_meas (
        .clk_148_5    (clk_148_5),
        .reset_n      (reset_n),
        .tick_i       (1'b1),
        .active_i     (de_q),
        .lead_i       (hs_lead),
        .period_o     (line_len),
        .active_len_o (de_len)
    );

    vid_axis_meas #(
        .HOLD_ACTIVE (1'b0)
    ) u_v_meas (
        .clk_148_5    (clk_148_5),
        .reset_n      (reset_n),
        .tick_i       (hs_lead),
        .active_i     (line_has_de),
        .lead_i       (vs_lead),
        .period_o     (v_total),
        .active_len_o (v_active)
    );

    assign fmt_ok = (line_len == CNT_W'(H_TOTAL)) && (de_len == CNT_W'(H_ACTIVE)) &&
                    (v_total == CNT_W'(V_TOTAL)) && (v_active == CNT_W'(V_ACTIVE));

    always_ff @(posedge clk_148_5 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StSearch;
            match_cnt_q   <= '0;
            meas_h_total  <= '0;
            meas_h_active <= '0;
            meas_v_total  <= '0;
            meas_v_active <= '0;
            meas_valid    <= 1'b0;
            fmt_match     <= 1'b0;
            locked        <= 1'b0;
            frame_done    <= 1'b0;
            frame_sum     <= '0;
            err_count     <= '0;
        end else begin
            frame_done <= 1'b0;
            if (timeout) begin
                state_q     <= StSearch;
                match_cnt_q <= '0;
                meas_valid  <= 1'b0;
                fmt_match   <= 1'b0;
                locked      <= 1'b0;
            end else if (vs_edge_q) begin
                // The first edge after SEARCH only opens a frame; nothing complete to capture
                if (state_q != StSearch) begin
                    meas_h_total  <= line_len;
                    meas_h_active <= de_len;
                    meas_v_total  <= v_total;
                    meas_v_active <= v_active;
                    frame_sum     <= sum_snap_q;
                    frame_done    <= 1'b1;
                    meas_valid    <= 1'b1;
                    fmt_match     <= fmt_ok;
                end
                case (state_q)
                    StSearch: state_q <= StMeasure;
                    StMeasure: begin
                        if (fmt_ok) begin
                            match_cnt_q <= match_cnt_q + 4'd1;
                            if (match_cnt_q == LOCK_N - 4'd1) begin
                                state_q <= StLocked;
                                locked  <= 1'b1;
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                    StLocked: begin
                        if (!fmt_ok) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            state_q     <= StMeasure;
                            match_cnt_q <= '0;
                            locked      <= 1'b0;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

endmodule
